// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types for the GCD host sequencer
package gcd_pkg;

    localparam int GCD_NBITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAPTURE,
        OUT,
        ABORT
    } gcd_host_state_t;

    typedef struct packed {
        logic [GCD_NBITS-1:0] x;
        logic [GCD_NBITS-1:0] y;
    } gcd_req_t;

endpackage

// File: rtl/gcd_host_sequencer_if.sv
// rtl/gcd_host_sequencer_if.sv - request, result and engine signals of the GCD host sequencer
interface gcd_host_sequencer_if #(
    parameter int NBITS = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [NBITS-1:0] req_x;
    logic [NBITS-1:0] req_y;
    logic             res_valid;
    logic             res_ready;
    logic [NBITS-1:0] res_gcd;
    logic             res_err;
    logic [NBITS-1:0] eng_xi;
    logic [NBITS-1:0] eng_yi;
    logic             eng_start;
    logic             eng_rst;
    logic             eng_rdy;
    logic [NBITS-1:0] eng_xo;
    logic             busy;

    modport slave (
        input  req_valid, req_x, req_y, res_ready, eng_rdy, eng_xo,
        output req_ready, res_valid, res_gcd, res_err, eng_xi, eng_yi,
               eng_start, eng_rst, busy
    );

    modport master (
        output req_valid, req_x, req_y, res_ready, eng_rdy, eng_xo,
        input  req_ready, res_valid, res_gcd, res_err, eng_xi, eng_yi,
               eng_start, eng_rst, busy
    );
endinterface

// File: rtl/gcd_req_fifo.sv
// rtl/gcd_req_fifo.sv - synchronous request FIFO with wrap-bit pointers
module gcd_req_fifo
    import gcd_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = gcd_req_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    T             mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/gcd_host_sequencer.sv
// rtl/gcd_host_sequencer.sv - sequences buffered operand pairs into a GCD engine; optional watchdog via GCD_TIMEOUT_EN
module gcd_host_sequencer
    import gcd_pkg::*;
#(
    parameter int NBITS      = GCD_NBITS,
    parameter int FIFO_DEPTH = 4,
    parameter int LOAD_CYC   = 2,
    parameter int MAX_CYC    = 1024
) (
    input logic               clk,
    input logic               rst,
    gcd_host_sequencer_if.slave bus
);
    typedef struct packed {
        logic [NBITS-1:0] x;
        logic [NBITS-1:0] y;
    } req_t;

    localparam int           LW        = $clog2(LOAD_CYC + 1);
    localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_CYC - 1);

    gcd_host_state_t  state;
    logic [LW-1:0]    load_cnt;
    logic [NBITS-1:0] xi;
    logic [NBITS-1:0] yi;
    logic             start;
    logic             res_valid;
    logic [NBITS-1:0] res_gcd;
    logic             rst_pulse;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    req_t             push_data;
    req_t             head;

    assign push_data = '{x: bus.req_x, y: bus.req_y};
    assign bus.req_ready = !full && !rst;
    assign push          = bus.req_valid && bus.req_ready;

    // The FIFO head is consumed in the same cycle the FSM moves into LOAD
    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = !empty;
            OUT:     pop = bus.res_ready && !empty;
            default: pop = 1'b0;
        endcase
    end

    gcd_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

`ifdef GCD_TIMEOUT_EN
    localparam int           RW       = $clog2(MAX_CYC + 1);
    localparam logic [RW-1:0] RUN_LAST = RW'(MAX_CYC - 1);

    logic [RW-1:0] run_cnt;
    logic          res_err_q;
    logic          abort_rst;

    assign bus.res_err = res_err_q;
    assign bus.eng_rst = (rst_pulse && !rst) || abort_rst;
`else
    assign bus.res_err = 1'b0;
    assign bus.eng_rst = rst_pulse && !rst;
`endif

    assign bus.eng_xi    = xi;
    assign bus.eng_yi    = yi;
    assign bus.eng_start = start;
    assign bus.res_valid = res_valid;
    assign bus.res_gcd   = res_gcd;
    assign bus.busy      = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            load_cnt  <= '0;
            xi        <= '0;
            yi        <= '0;
            start     <= 1'b0;
            res_valid <= 1'b0;
            res_gcd   <= '0;
            rst_pulse <= 1'b1;
`ifdef GCD_TIMEOUT_EN
            run_cnt   <= '0;
            res_err_q <= 1'b0;
            abort_rst <= 1'b0;
`endif
        end else begin
            rst_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        xi       <= head.x;
                        yi       <= head.y;
                        load_cnt <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (load_cnt == LOAD_LAST) begin
                        start <= 1'b1;
                        state <= RUN;
`ifdef GCD_TIMEOUT_EN
                        run_cnt <= '0;
`endif
                    end else begin
                        load_cnt <= load_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (bus.eng_rdy) begin
                        state <= CAPTURE;
                    end
`ifdef GCD_TIMEOUT_EN
                    else if (run_cnt == RUN_LAST) begin
                        start     <= 1'b0;
                        abort_rst <= 1'b1;
                        state     <= ABORT;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
`endif
                end
                CAPTURE: begin
                    res_gcd   <= bus.eng_xo;
                    res_valid <= 1'b1;
                    start     <= 1'b0;
                    state     <= OUT;
`ifdef GCD_TIMEOUT_EN
                    res_err_q <= 1'b0;
`endif
                end
`ifdef GCD_TIMEOUT_EN
                ABORT: begin
                    abort_rst <= 1'b0;
                    res_gcd   <= '0;
                    res_err_q <= 1'b1;
                    res_valid <= 1'b1;
                    state     <= OUT;
                end
`endif
                OUT: begin
                    if (bus.res_ready) begin
                        res_valid <= 1'b0;
                        if (!empty) begin
                            xi       <= head.x;
                            yi       <= head.y;
                            load_cnt <= '0;
                            state    <= LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_host_sequencer.sv
// tb/tb_gcd_host_sequencer.sv - directed vectors for gcd_host_sequencer with a behavioural engine
module tb_gcd_host_sequencer;
    localparam int NB = 8;
    localparam int LC = 2;
    localparam int MC = 16;

    typedef struct {
        logic [NB-1:0] x;
        logic [NB-1:0] y;
        logic [NB-1:0] gcd;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gcd_host_sequencer_if #(.NBITS(NB)) bus ();

    gcd_host_sequencer #(
        .NBITS      (NB),
        .FIFO_DEPTH (4),
        .LOAD_CYC   (LC),
        .MAX_CYC    (MC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Subtractive GCD engine on operand magnitudes; stub_hang keeps it from finishing
    logic [NB-1:0] ea, eb, exo;
    logic          erdy;
    logic          stub_hang;

    function automatic logic [NB-1:0] mag(input logic [NB-1:0] v);
        return v[NB-1] ? (~v + 1'b1) : v;
    endfunction

    assign bus.eng_rdy = erdy;
    assign bus.eng_xo  = exo;

    always @(posedge clk) begin
        if (rst || bus.eng_rst || !bus.eng_start) begin
            ea   <= mag(bus.eng_xi);
            eb   <= mag(bus.eng_yi);
            erdy <= 1'b0;
        end else if (!erdy && !stub_hang) begin
            if (ea == 0 || eb == 0) begin
                exo  <= '0;
                erdy <= 1'b1;
            end else if (ea == eb) begin
                exo  <= ea;
                erdy <= 1'b1;
            end else if (ea > eb) begin
                ea <= ea - eb;
            end else begin
                eb <= eb - ea;
            end
        end
    end

    int   low_run   = 0;
    int   min_low   = 1000;
    int   rst_edges = 0;
    logic prev_start = 1'b0;
    logic prev_erst  = 1'b0;

    always @(negedge clk) begin
        if (bus.eng_start && !prev_start && low_run < min_low) min_low = low_run;
        low_run = bus.eng_start ? 0 : low_run + 1;
        if (bus.eng_rst && !prev_erst) rst_edges++;
        prev_start = bus.eng_start;
        prev_erst  = bus.eng_rst;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic push_pair(input logic [NB-1:0] x, input logic [NB-1:0] y);
        int n = 0;
        bus.req_x     = x;
        bus.req_y     = y;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("push_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_result(output logic ok, output logic [NB-1:0] run_xi, output int run_cyc);
        int n = 0;
        logic seen = 1'b0;
        run_cyc = 0;
        run_xi  = '0;
        while (!bus.res_valid && n < 300) begin
            if (bus.eng_start) begin
                if (!seen) run_xi = bus.eng_xi;
                seen = 1'b1;
                run_cyc++;
            end
            @(negedge clk);
            n++;
        end
        ok = bus.res_valid;
    endtask

    task automatic accept();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    vec_t          vecs[7];
    logic [NB-1:0] b2b_exp[4];
    logic          ok;
    logic [NB-1:0] rxi;
    logic [NB-1:0] held;
    logic          stable;
    int            rc;
    int            n;
    int            edges0;

    initial begin
        vecs[0] = '{8'd12,  8'd18,  8'd6};
        vecs[1] = '{8'd0,   8'd5,   8'd0};
        vecs[2] = '{8'hF4,  8'd18,  8'd6};
        vecs[3] = '{8'd5,   8'd0,   8'd0};
        vecs[4] = '{8'hF7,  8'hFA,  8'd3};
        vecs[5] = '{8'd1,   8'hFF,  8'd1};
        vecs[6] = '{8'd100, 8'd75,  8'd25};
        b2b_exp = '{8'd7, 8'd4, 8'd5, 8'd7};

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.res_ready = 1'b0;
        stub_hang     = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_gcd", bus.res_gcd, 0);
        check("rst_res_err", bus.res_err, 0);
        check("rst_eng_start", bus.eng_start, 0);
        check("rst_eng_xi", bus.eng_xi, 0);
        check("rst_eng_yi", bus.eng_yi, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_eng_rst_during", bus.eng_rst, 0);

        rst = 1'b0;
        #1;
        check("post_rst_eng_rst", bus.eng_rst, 1);
        check("post_rst_req_ready", bus.req_ready, 1);
        @(negedge clk);
        check("post_rst_eng_rst_clear", bus.eng_rst, 0);

        for (int i = 0; i < 7; i++) begin
            push_pair(vecs[i].x, vecs[i].y);
            wait_result(ok, rxi, rc);
            check($sformatf("vec%0d_valid", i), ok, 1);
            check($sformatf("vec%0d_gcd", i), bus.res_gcd, vecs[i].gcd);
            check($sformatf("vec%0d_err", i), bus.res_err, 0);
            check($sformatf("vec%0d_run_xi", i), rxi, vecs[i].x);
            accept();
        end

        // Back-to-back pairs with the first result held unaccepted
        push_pair(8'd9, 8'd6);
        wait_result(ok, rxi, rc);
        check("b2b0_valid", ok, 1);
        check("b2b0_gcd", bus.res_gcd, 3);
        held   = bus.res_gcd;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.res_valid || bus.res_gcd !== held || bus.eng_start) stable = 1'b0;
        end
        check("hold_stable", stable, 1);
        push_pair(8'd7, 8'd7);
        push_pair(8'd8, 8'd12);
        push_pair(8'd15, 8'd25);
        push_pair(8'd14, 8'd21);
        check("fifo_full_ready", bus.req_ready, 0);
        check("fifo_full_busy", bus.busy, 1);
        check("fifo_full_no_start", bus.eng_start, 0);
        accept();
        check("ready_after_pop", bus.req_ready, 1);
        for (int i = 0; i < 4; i++) begin
            wait_result(ok, rxi, rc);
            check($sformatf("b2b%0d_valid", i + 1), ok, 1);
            check($sformatf("b2b%0d_gcd", i + 1), bus.res_gcd, b2b_exp[i]);
            accept();
        end
        check("idle_not_busy", bus.busy, 0);

        // Reset while the engine is running discards the pair
        stub_hang = 1'b1;
        push_pair(8'd12, 8'd18);
        n = 0;
        while (!bus.eng_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reached_run", bus.eng_start, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_rst_busy", bus.busy, 0);
        check("midrun_rst_valid", bus.res_valid, 0);
        check("midrun_rst_ready", bus.req_ready, 0);
        rst       = 1'b0;
        stub_hang = 1'b0;
        stable    = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.res_valid || bus.busy) stable = 1'b0;
        end
        check("midrun_no_result", stable, 1);

`ifdef GCD_TIMEOUT_EN
        stub_hang = 1'b1;
        edges0    = rst_edges;
        push_pair(8'd20, 8'd30);
        wait_result(ok, rxi, rc);
        check("wd_valid", ok, 1);
        check("wd_err", bus.res_err, 1);
        check("wd_gcd", bus.res_gcd, 0);
        check("wd_run_cycles", rc, MC);
        check("wd_eng_rst_pulses", rst_edges - edges0, 1);
        accept();
        stub_hang = 1'b0;
        push_pair(8'd12, 8'd18);
        wait_result(ok, rxi, rc);
        check("wd_recover_gcd", bus.res_gcd, 6);
        check("wd_recover_err", bus.res_err, 0);
        accept();
`else
        edges0 = rst_edges;
`endif

        check("start_low_min", (min_low >= LC) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
